draw_text_box: RTL

// - Parametrised successor of the fixed-size text-rectangle draw stages in the VGA chain.
// - Draws a COLS x ROWS grid of font characters, each scaled by 2^SCALE_LOG2, at (X_POS,Y_POS).
// - Drives char_yx/char_line to an external *_writing + font ROM pair and composites the returned char_pixels over rgb_in.
// - Delays all timing signals to keep the chain aligned; it drops in between any two draw stages.

---
 rtl/draw_text_box.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/draw_text_box.sv
// Text-box draw stage: overlays a COLS x ROWS grid of scaled font glyphs on the VGA stream.
// Optional TEXT_BLINK_EN macro: blinks glyphs using a vsync-driven frame counter.
//
// Ports:
//   pclk, rst (sync, active-low)       clock and reset
//   *_in timing, rgb_in                upstream VGA stream
//   *_out timing, rgb_out              stream delayed by FONT_LAT+2
//   enable                             show request, taken at vsync rise
//   char_yx, char_line, char_pixels    font ROM address/data loop
module draw_text_box #(
  parameter int          X_POS      = 232,
  parameter int          Y_POS      = 380,
  parameter int          COLS       = 16,
  parameter int          ROWS       = 1,
  parameter int          CHAR_W     = 8,
  parameter int          CHAR_H     = 16,
  parameter int          SCALE_LOG2 = 0,
  parameter int          FONT_LAT   = 2,
  parameter logic [11:0] FG_COLOR   = 12'hFFF,
  parameter bit          BG_EN      = 1'b0,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter int          BLINK_LOG2 = 5
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [10:0]       hcount_in,
  input  logic              hsync_in,
  input  logic              hblnk_in,
  input  logic [10:0]       vcount_in,
  input  logic              vsync_in,
  input  logic              vblnk_in,
  input  logic [11:0]       rgb_in,
  input  logic              enable,
  input  logic [CHAR_W-1:0] char_pixels,
  output logic [10:0]       hcount_out,
  output logic              hsync_out,
  output logic              hblnk_out,
  output logic [10:0]       vcount_out,
  output logic              vsync_out,
  output logic              vblnk_out,
  output logic [11:0]       rgb_out,
  output logic [7:0]        char_yx,
  output logic [7:0]        char_line
);

  localparam int BOX_W = (COLS * CHAR_W) << SCALE_LOG2;
  localparam int BOX_H = (ROWS * CHAR_H) << SCALE_LOG2;
  localparam int BW    = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;

  typedef struct packed {
    logic [10:0]   hcount;
    logic          hsync;
    logic          hblnk;
    logic [10:0]   vcount;
    logic          vsync;
    logic          vblnk;
    logic [11:0]   rgb;
    logic          in_box;
    logic [BW-1:0] bit_idx;
  } tap_t;

  logic [31:0] h, v, dx, dy;
  logic [31:0] col, row, line, bit_w;
  logic        in_box_c;
  tap_t        tap_c;
  tap_t        pipe [0:FONT_LAT];
  tap_t        tb_q;
  logic        vsync_q;
  logic        en_q;
  logic        px;
  logic        blink_on;
  logic [11:0] rgb_nxt;

  always_comb begin
    h        = {21'd0, hcount_in};
    v        = {21'd0, vcount_in};
    in_box_c = (h >= 32'(X_POS)) && (h < 32'(X_POS + BOX_W)) &&
               (v >= 32'(Y_POS)) && (v < 32'(Y_POS + BOX_H));
    dx = '0;
    dy = '0;
    // Offsets forced to 0 outside the box so nothing wraps left/above it.
    if (in_box_c) begin
      dx = (h - 32'(X_POS)) >> SCALE_LOG2;
      dy = (v - 32'(Y_POS)) >> SCALE_LOG2;
    end
    col   = dx / 32'(CHAR_W);
    bit_w = 32'(CHAR_W - 1) - (dx % 32'(CHAR_W));
    row   = dy / 32'(CHAR_H);
    line  = dy % 32'(CHAR_H);
    tap_c = '{hcount: hcount_in, hsync: hsync_in,
              hblnk: hblnk_in, vcount: vcount_in,
              vsync: vsync_in, vblnk: vblnk_in,
              rgb: rgb_in, in_box: in_box_c,
              bit_idx: bit_w[BW-1:0]};
  end

  // pipe[0] is stage A; pipe[1..FONT_LAT] cover the font ROM latency.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      for (int i = 0; i <= FONT_LAT; i++) pipe[i] <= '0;
      char_yx   <= '0;
      char_line <= '0;
    end else begin
      pipe[0]   <= tap_c;
      for (int i = 1; i <= FONT_LAT; i++) pipe[i] <= pipe[i-1];
      char_yx   <= {row[3:0], col[3:0]};
      char_line <= line[7:0];
    end
  end

  // Enable only changes at frame start so a box is never torn.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      vsync_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      vsync_q <= vsync_in;
      if (vsync_in && !vsync_q) en_q <= enable;
    end
  end

`ifdef TEXT_BLINK_EN
  logic [5:0] frame_cnt;

  always_ff @(posedge pclk) begin
    if (!rst) frame_cnt <= '0;
    else if (vsync_in && !vsync_q) frame_cnt <= frame_cnt + 6'd1;
  end

  assign blink_on = ~frame_cnt[BLINK_LOG2];
`else
  assign blink_on = 1'b1;
`endif

  assign tb_q = pipe[FONT_LAT];
  assign px   = char_pixels[tb_q.bit_idx] & blink_on;

  always_comb begin
    rgb_nxt = tb_q.rgb;
    if (tb_q.hblnk || tb_q.vblnk)
      rgb_nxt = 12'h000;
    else if (en_q && tb_q.in_box && px)
      rgb_nxt = FG_COLOR;
    else if (en_q && tb_q.in_box && BG_EN)
      rgb_nxt = BG_COLOR;
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= tb_q.hcount;
      hsync_out  <= tb_q.hsync;
      hblnk_out  <= tb_q.hblnk;
      vcount_out <= tb_q.vcount;
      vsync_out  <= tb_q.vsync;
      vblnk_out  <= tb_q.vblnk;
      rgb_out    <= rgb_nxt;
    end
  end

endmodule
